// File: rtl/wide_alu_reg_initiator_if.sv
// Register bus between the wide-ALU initiator (master) and the ALU register-file target (slave).
interface wide_alu_reg_initiator_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   req_addr;
  logic            req_write;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wstrb;
  logic            req_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_error;
  logic            rsp_ready;

  modport master (
    output req_addr, req_write, req_wdata, req_wstrb, req_valid,
    input  rsp_rdata, rsp_error, rsp_ready
  );

  modport slave (
    input  req_addr, req_write, req_wdata, req_wstrb, req_valid,
    output rsp_rdata, rsp_error, rsp_ready
  );
endinterface

// File: rtl/wide_alu_reg_initiator.sv
// Register-bus initiator: loads wide-ALU operands, triggers, polls STATUS and reads back the
// double-width result, reporting a 2-bit error code to the local client.
module wide_alu_reg_initiator #(
  parameter int            ALU_WIDTH  = 256,
  parameter int            DW         = 32,
  parameter int            AW         = 32,
  parameter logic [AW-1:0] BASE_ADDR  = AW'(32'h0000_0000),
  parameter logic [AW-1:0] OP_A_OFS   = AW'(32'h0000_0000),
  parameter logic [AW-1:0] OP_B_OFS   = AW'(32'h0000_0020),
  parameter logic [AW-1:0] RESULT_OFS = AW'(32'h0000_0040),
  parameter logic [AW-1:0] CTRL1_OFS  = AW'(32'h0000_0080),
  parameter logic [AW-1:0] CTRL2_OFS  = AW'(32'h0000_0084),
  parameter logic [AW-1:0] STATUS_OFS = AW'(32'h0000_0088),
  parameter int            POLL_MAX   = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [ALU_WIDTH-1:0]   op_a_i,
  input  logic [ALU_WIDTH-1:0]   op_b_i,
  input  logic [2:0]             opsel_i,
  input  logic [3:0]             delay_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [2*ALU_WIDTH-1:0] result_o,
  output logic [1:0]             err_o,
  output logic                   busy_o,
  wide_alu_reg_initiator_if.master bus
);
  localparam int N  = ALU_WIDTH / DW;
  localparam int IW = $clog2(2 * N) + 1;
  localparam int PW = $clog2(POLL_MAX + 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BUS     = 2'd1;
  localparam logic [1:0] ERR_ALU     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_A     = 4'd1,
    WR_B     = 4'd2,
    WR_CTRL2 = 4'd3,
    TRIG     = 4'd4,
    POLL     = 4'd5,
    RD_RES   = 4'd6,
    CLR_ERR  = 4'd7,
    DONE     = 4'd8
  } state_t;

  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] ofs, input logic [IW-1:0] idx);
    return BASE_ADDR + ofs + AW'({idx, 2'b00});
  endfunction

  state_t                 state_r, state_s;
  logic [IW-1:0]          idx_r, idx_s, nidx_s;
  logic [PW-1:0]          poll_r, poll_s, poll_nxt_s;
  logic [ALU_WIDTH-1:0]   op_a_r, op_a_s, op_b_r, op_b_s;
  logic [2:0]             opsel_r, opsel_s;
  logic [3:0]             delay_r, delay_s;
  logic [2*ALU_WIDTH-1:0] result_r, result_s;
  logic [1:0]             err_r, err_s;
  logic [AW-1:0]          req_addr_r, req_addr_s, addr_s;
  logic [DW-1:0]          req_wdata_r, req_wdata_s, wdata_s;
  logic [DW/8-1:0]        req_wstrb_r, req_wstrb_s;
  logic                   req_write_r, req_write_s, req_valid_r, req_valid_s;
  logic                   res_valid_r, res_valid_s, busy_r, busy_s, job_ready_r, job_ready_s;
  logic                   xfer_s, load_s, issue_s, wr_s;

  assign xfer_s     = req_valid_r & bus.rsp_ready;
  assign nidx_s     = idx_r + IW'(1'b1);
  assign poll_nxt_s = poll_r + PW'(1'b1);

  // Next-state, next-request and result/error update for the job sequencer.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    poll_s   = poll_r;
    op_a_s   = op_a_r;
    op_b_s   = op_b_r;
    opsel_s  = opsel_r;
    delay_s  = delay_r;
    result_s = result_r;
    err_s    = err_r;
    load_s   = 1'b0;
    issue_s  = 1'b0;
    wr_s     = 1'b0;
    addr_s   = '0;
    wdata_s  = '0;

    if (state_r == IDLE) begin
      if (job_valid_i) begin
        op_a_s   = op_a_i;
        op_b_s   = op_b_i;
        opsel_s  = opsel_i;
        delay_s  = delay_i;
        result_s = '0;
        err_s    = ERR_OK;
        idx_s    = '0;
        state_s  = WR_A;
        load_s   = 1'b1;
        issue_s  = 1'b1;
        wr_s     = 1'b1;
        addr_s   = word_addr(OP_A_OFS, '0);
        wdata_s  = op_a_i[DW-1:0];
      end else begin
        state_s = IDLE;
      end
    end else if (state_r == DONE) begin
      if (res_ready_i) begin
        state_s = IDLE;
      end else begin
        state_s = DONE;
      end
    end else if (!xfer_s) begin
      state_s = state_r;
    end else if (bus.rsp_error && (state_r != CLR_ERR)) begin
      // A failing clear-error write must not overwrite the ALU error code.
      state_s = DONE;
      err_s   = ERR_BUS;
      load_s  = 1'b1;
    end else begin
      load_s = 1'b1;
      case (state_r)
        WR_A: begin
          issue_s = 1'b1;
          wr_s    = 1'b1;
          if (idx_r == IW'(N - 1)) begin
            state_s = WR_B;
            idx_s   = '0;
            addr_s  = word_addr(OP_B_OFS, '0);
            wdata_s = op_b_r[DW-1:0];
          end else begin
            idx_s   = nidx_s;
            addr_s  = word_addr(OP_A_OFS, nidx_s);
            wdata_s = op_a_r[nidx_s*DW +: DW];
          end
        end
        WR_B: begin
          issue_s = 1'b1;
          wr_s    = 1'b1;
          if (idx_r == IW'(N - 1)) begin
            state_s = WR_CTRL2;
            idx_s   = '0;
            addr_s  = CTRL2_OFS + BASE_ADDR;
            wdata_s = DW'({delay_r, 5'b00000, opsel_r});
          end else begin
            idx_s   = nidx_s;
            addr_s  = word_addr(OP_B_OFS, nidx_s);
            wdata_s = op_b_r[nidx_s*DW +: DW];
          end
        end
        WR_CTRL2: begin
          state_s = TRIG;
          issue_s = 1'b1;
          wr_s    = 1'b1;
          addr_s  = CTRL1_OFS + BASE_ADDR;
          wdata_s = DW'(1'b1);
        end
        TRIG: begin
          state_s = POLL;
          poll_s  = '0;
          issue_s = 1'b1;
          addr_s  = STATUS_OFS + BASE_ADDR;
        end
        POLL: begin
          if (bus.rsp_rdata[1]) begin
            state_s = CLR_ERR;
            err_s   = ERR_ALU;
            issue_s = 1'b1;
            wr_s    = 1'b1;
            addr_s  = CTRL1_OFS + BASE_ADDR;
            wdata_s = DW'(2'b10);
          end else if (bus.rsp_rdata[0] && (poll_nxt_s == PW'(POLL_MAX))) begin
            state_s = DONE;
            err_s   = ERR_TIMEOUT;
          end else if (bus.rsp_rdata[0]) begin
            poll_s  = poll_nxt_s;
            issue_s = 1'b1;
            addr_s  = STATUS_OFS + BASE_ADDR;
          end else begin
            state_s = RD_RES;
            idx_s   = '0;
            issue_s = 1'b1;
            addr_s  = word_addr(RESULT_OFS, '0);
          end
        end
        RD_RES: begin
          result_s[idx_r*DW +: DW] = bus.rsp_rdata;
          if (idx_r == IW'(2 * N - 1)) begin
            state_s = DONE;
            err_s   = ERR_OK;
          end else begin
            idx_s   = nidx_s;
            issue_s = 1'b1;
            addr_s  = word_addr(RESULT_OFS, nidx_s);
          end
        end
        CLR_ERR: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    if (load_s) begin
      req_valid_s = issue_s;
      req_write_s = issue_s & wr_s;
      req_addr_s  = addr_s;
      req_wdata_s = wdata_s;
      req_wstrb_s = {(DW/8){issue_s & wr_s}};
    end else begin
      req_valid_s = req_valid_r;
      req_write_s = req_write_r;
      req_addr_s  = req_addr_r;
      req_wdata_s = req_wdata_r;
      req_wstrb_s = req_wstrb_r;
    end

    res_valid_s = (state_s == DONE);
    busy_s      = (state_s != IDLE);
    job_ready_s = (state_s == IDLE);
  end

  // State, job context, request and client-side output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      poll_r      <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      opsel_r     <= 3'd0;
      delay_r     <= 4'd0;
      result_r    <= '0;
      err_r       <= ERR_OK;
      req_valid_r <= 1'b0;
      req_write_r <= 1'b0;
      req_addr_r  <= '0;
      req_wdata_r <= '0;
      req_wstrb_r <= '0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      job_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      poll_r      <= poll_s;
      op_a_r      <= op_a_s;
      op_b_r      <= op_b_s;
      opsel_r     <= opsel_s;
      delay_r     <= delay_s;
      result_r    <= result_s;
      err_r       <= err_s;
      req_valid_r <= req_valid_s;
      req_write_r <= req_write_s;
      req_addr_r  <= req_addr_s;
      req_wdata_r <= req_wdata_s;
      req_wstrb_r <= req_wstrb_s;
      res_valid_r <= res_valid_s;
      busy_r      <= busy_s;
      job_ready_r <= job_ready_s;
    end
  end

  assign job_ready_o   = job_ready_r;
  assign res_valid_o   = res_valid_r;
  assign busy_o        = busy_r;
  assign result_o      = result_r;
  assign err_o         = err_r;
  assign bus.req_valid = req_valid_r;
  assign bus.req_write = req_write_r;
  assign bus.req_addr  = req_addr_r;
  assign bus.req_wdata = req_wdata_r;
  assign bus.req_wstrb = req_wstrb_r;
endmodule

// File: tb/tb_wide_alu_reg_initiator.sv
// Randomized directed bench: a register-file target responder plus a transaction-list reference model.
module tb_wide_alu_reg_initiator;
  localparam int AW = 32, DW = 32, ALU_WIDTH = 256, N = 8, POLL_MAX = 8, RW = 2 * ALU_WIDTH;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 job_valid = 1'b0, job_ready, res_valid, res_ready = 1'b0, busy;
  logic [ALU_WIDTH-1:0] op_a = '0, op_b = '0;
  logic [2:0]           opsel = 3'd0;
  logic [3:0]           delay = 4'd0;
  logic [RW-1:0]        result;
  logic [1:0]           err;

  wide_alu_reg_initiator_if #(.AW(AW), .DW(DW)) bus();

  wide_alu_reg_initiator #(.ALU_WIDTH(ALU_WIDTH), .DW(DW), .AW(AW), .POLL_MAX(POLL_MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .job_valid_i(job_valid), .job_ready_o(job_ready),
    .op_a_i(op_a), .op_b_i(op_b), .opsel_i(opsel), .delay_i(delay),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .result_o(result), .err_o(err),
    .busy_o(busy), .bus(bus.master)
  );

  int checks = 0, errors = 0;

  // Expected transaction list for the current job.
  logic [AW-1:0] e_addr[$];
  logic          e_wr[$];
  logic [DW-1:0] e_wdata[$];

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ALU_WIDTH-1:0] rand_op();
    logic [ALU_WIDTH-1:0] v;
    for (int i = 0; i < ALU_WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic push(input logic [AW-1:0] ad, input logic wr, input logic [DW-1:0] wd);
    e_addr.push_back(ad);
    e_wr.push_back(wr);
    e_wdata.push_back(wd);
  endtask

  task automatic build_model(input logic [ALU_WIDTH-1:0] a, b, input logic [2:0] os, input logic [3:0] dl,
                             input int busy_polls, input bit alu_err, input int err_at,
                             input logic [RW-1:0] rv, output logic [1:0] xerr, output logic [RW-1:0] xres);
    bit timeout;
    int n_poll;
    e_addr.delete(); e_wr.delete(); e_wdata.delete();
    for (int i = 0; i < N; i++) push(32'h0000_0000 + 4 * i, 1'b1, a[i*32 +: 32]);
    for (int i = 0; i < N; i++) push(32'h0000_0020 + 4 * i, 1'b1, b[i*32 +: 32]);
    push(32'h0000_0084, 1'b1, {20'd0, dl, 5'd0, os});
    push(32'h0000_0080, 1'b1, 32'h0000_0001);
    timeout = (busy_polls >= POLL_MAX);
    n_poll  = timeout ? POLL_MAX : busy_polls + 1;
    for (int i = 0; i < n_poll; i++) push(32'h0000_0088, 1'b0, 32'h0);
    xerr = timeout ? 2'd3 : (alu_err ? 2'd2 : 2'd0);
    xres = '0;
    if (!timeout && alu_err) push(32'h0000_0080, 1'b1, 32'h0000_0002);
    if (!timeout && !alu_err) for (int i = 0; i < 2 * N; i++) push(32'h0000_0040 + 4 * i, 1'b0, 32'h0);
    for (int t = 0; t < e_addr.size(); t++) begin
      if (t == err_at && !(e_addr[t] == 32'h80 && e_wdata[t] == 32'h2)) begin
        xerr = 2'd1;
        while (e_addr.size() > t + 1) begin
          void'(e_addr.pop_back()); void'(e_wr.pop_back()); void'(e_wdata.pop_back());
        end
        break;
      end
      if (!e_wr[t] && e_addr[t] >= 32'h40 && e_addr[t] < 32'h80) begin
        int w;
        w = int'((e_addr[t] - 32'h40) >> 2);
        xres[w*32 +: 32] = rv[w*32 +: 32];
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/job_ready"}, RW'(job_ready), RW'(1'b1));
    chk({tag, "/res_valid"}, RW'(res_valid), RW'(1'b0));
    chk({tag, "/busy"}, RW'(busy), RW'(1'b0));
    chk({tag, "/req_valid"}, RW'(bus.req_valid), RW'(1'b0));
    chk({tag, "/req_write"}, RW'(bus.req_write), RW'(1'b0));
    chk({tag, "/req_fields"}, RW'({bus.req_addr, bus.req_wdata, bus.req_wstrb}), RW'(1'b0));
    chk({tag, "/result_err"}, RW'({result, err}), RW'(1'b0));
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
  task automatic run_job(input string tag, input logic [ALU_WIDTH-1:0] a, b, input logic [2:0] os,
                         input logic [3:0] dl, input int stall, input int busy_polls, input bit alu_err,
                         input int err_at, input logic [RW-1:0] rv, input int hold);
    logic [1:0]    xerr;
    logic [RW-1:0] xres;
    logic [AW+DW+1+DW/8-1:0] snap;
    int exp_cyc, cyc, t, wait_c, polls;
    build_model(a, b, os, dl, busy_polls, alu_err, err_at, rv, xerr, xres);
    exp_cyc = 1 + e_addr.size() * (stall + 1);
    chk({tag, "/ready_before"}, RW'(job_ready), RW'(1'b1));
    job_valid = 1'b1; op_a = a; op_b = b; opsel = os; delay = dl;
    @(posedge clk); @(negedge clk);
    job_valid = 1'b0; op_a = rand_op(); op_b = rand_op(); opsel = 3'($urandom()); delay = 4'($urandom());
    chk({tag, "/busy_in_flight"}, RW'({busy, job_ready}), RW'(2'b10));
    cyc = 1; t = 0; wait_c = 0; polls = 0; snap = '0;
    while (!res_valid && cyc < 4000) begin
      bus.rsp_ready = 1'b0; bus.rsp_error = 1'b0; bus.rsp_rdata = '0;
      if (bus.req_valid) begin
        if (wait_c == 0) snap = {bus.req_addr, bus.req_wdata, bus.req_write, bus.req_wstrb};
        else chk({tag, "/stall_stable"}, RW'({bus.req_addr, bus.req_wdata, bus.req_write, bus.req_wstrb}), RW'(snap));
        if (wait_c == stall) begin
          bus.rsp_ready = 1'b1;
          wait_c = 0;
          if (t < e_addr.size()) begin
            chk({tag, "/addr"}, RW'(bus.req_addr), RW'(e_addr[t]));
            chk({tag, "/write"}, RW'(bus.req_write), RW'(e_wr[t]));
            chk({tag, "/wstrb"}, RW'(bus.req_wstrb), RW'(e_wr[t] ? 4'hF : 4'h0));
            if (e_wr[t]) chk({tag, "/wdata"}, RW'(bus.req_wdata), RW'(e_wdata[t]));
          end else begin
            chk({tag, "/extra_request"}, RW'(t), RW'(e_addr.size()));
          end
          if (!bus.req_write && bus.req_addr == 32'h88) begin
            bus.rsp_rdata = (polls < busy_polls) ? 32'h1 : (alu_err ? 32'h2 : 32'h0);
            polls++;
          end else if (!bus.req_write && bus.req_addr >= 32'h40 && bus.req_addr < 32'h80) begin
            bus.rsp_rdata = rv[int'((bus.req_addr - 32'h40) >> 2)*32 +: 32];
          end else begin
            bus.rsp_rdata = 32'($urandom());
          end
          bus.rsp_error = (t == err_at);
          t++;
        end else begin
          wait_c++;
        end
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    bus.rsp_ready = 1'b0; bus.rsp_error = 1'b0; bus.rsp_rdata = '0;
    chk({tag, "/res_valid"}, RW'(res_valid), RW'(1'b1));
    chk({tag, "/latency"}, RW'(cyc), RW'(exp_cyc));
    chk({tag, "/txn_count"}, RW'(t), RW'(e_addr.size()));
    chk({tag, "/err"}, RW'(err), RW'(xerr));
    chk({tag, "/result"}, result, xres);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk({tag, "/hold_state"}, RW'({res_valid, job_ready, busy, bus.req_valid, err}), RW'({4'b1010, xerr}));
      chk({tag, "/hold_result"}, result, xres);
    end
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "/released"}, RW'({res_valid, job_ready, busy}), RW'(3'b010));
  endtask

  initial begin
    logic [ALU_WIDTH-1:0] ra, rb;
    bus.rsp_ready = 1'b0; bus.rsp_error = 1'b0; bus.rsp_rdata = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("after_reset");

    run_job("basic", ALU_WIDTH'(1), ALU_WIDTH'(2), 3'd0, 4'd0, 0, 0, 1'b0, -1, RW'(3), 1);
    run_job("stall3", ALU_WIDTH'(1), ALU_WIDTH'(2), 3'd0, 4'd0, 3, 0, 1'b0, -1, RW'(3), 2);
    run_job("rand_stall", rand_op(), rand_op(), 3'($urandom()), 4'($urandom()), 1, 2, 1'b0, -1,
            {rand_op(), rand_op()}, 2);
    run_job("busy5", rand_op(), rand_op(), 3'd5, 4'hA, 0, 5, 1'b0, -1, {rand_op(), rand_op()}, 1);
    run_job("busy_max_minus1", rand_op(), rand_op(), 3'd7, 4'hF, 0, POLL_MAX - 1, 1'b0, -1,
            {rand_op(), rand_op()}, 1);
    run_job("alu_err", rand_op(), rand_op(), 3'd3, 4'h6, 0, 1, 1'b1, -1, {rand_op(), rand_op()}, 1);
    run_job("bus_err_opb3", rand_op(), rand_op(), 3'd1, 4'h2, 0, 0, 1'b0, 2 * N - N + 2,
            {rand_op(), rand_op()}, 1);
    run_job("bus_err_rd5", rand_op(), rand_op(), 3'd2, 4'h1, 1, 0, 1'b0, 2 * N + 3 + 4,
            {rand_op(), rand_op()}, 1);
    run_job("bus_err_clr", rand_op(), rand_op(), 3'd4, 4'h3, 0, 0, 1'b1, 2 * N + 3, {rand_op(), rand_op()}, 1);
    run_job("timeout", rand_op(), rand_op(), 3'd6, 4'h9, 0, 1000, 1'b0, -1, {rand_op(), rand_op()}, 10);

    // Reset in the middle of the op_b writes with the target always ready.
    ra = rand_op(); rb = rand_op();
    job_valid = 1'b1; op_a = ra; op_b = rb; opsel = 3'd2; delay = 4'h4;
    @(posedge clk); @(negedge clk);
    job_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (11) @(negedge clk);
    chk("midjob/addr", RW'({bus.req_valid, bus.req_addr}), RW'({1'b1, 32'h0000_002C}));
    chk("midjob/wdata", RW'(bus.req_wdata), RW'(rb[3*32 +: 32]));
    #1 rst_n = 1'b0;
    #1 chk_reset("midjob_reset");
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("midjob_release");
    run_job("post_reset", ra, rb, 3'd2, 4'h4, 0, 0, 1'b0, -1, {rand_op(), rand_op()}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
